// File: rtl/rx_buf_packer_pkg.sv
// Shared types and sizing for the RX frame buffer.
package rx_buf_pkg;

    localparam int WORDS     = 512;
    localparam int MAX_BYTES = 4 * WORDS;
    localparam int CNT_W     = 12;
    localparam int ADDR_W    = 9;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } rx_state_e;

endpackage

// File: rtl/rx_buf_packer_ram.sv
// 512x32 simple dual-port RAM, one clock, registered read port.
// Behavioural model; an ASIC macro drops in here with the same ports.
module rx_buf_ram_512x32
    import rx_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Write port; storage itself is not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data holds when no read is requested; same-address write returns old data.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    // Read output register, cleared by reset so the bus sees 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rx_buf_packer.sv
// RX frame buffer: packs MAC bytes little-endian into 32-bit words and
// holds one frame for the bus side until it is acknowledged.
//
// state | meaning
// ------+----------------------------------------------------------
// RECV  | accepting bytes of a new frame into the buffer
// HOLD  | complete frame held; incoming frames are counted as drops
// DROP  | discarding the tail of a frame that began during HOLD
module rx_buf_packer
    import rx_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_last_i,
    input  logic              rx_err_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o,
    output logic              frame_valid_o,
    output logic [CNT_W-1:0]  frame_len_o,
    output logic              frame_err_o,
    input  logic              frame_ack_i,
    output logic [15:0]       drop_cnt_o
);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       pack_q, pack_d;
    logic              ovf_q, ovf_d;
    logic              in_frame_q, in_frame_d;
    logic              done_q, done_d;
    logic              frame_valid_q, frame_valid_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              err_q, err_d;
    logic [15:0]       drop_q, drop_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    logic              full;
    logic [31:0]       word_next;

    // Next-state, packing, counting and frame bookkeeping.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pack_d        = pack_q;
        ovf_d         = ovf_q;
        in_frame_d    = in_frame_q;
        done_d        = 1'b0;
        frame_valid_d = frame_valid_q | done_q;
        len_d         = len_q;
        err_d         = err_q;
        drop_d        = drop_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;

        full      = (cnt_q == CNT_W'(MAX_BYTES));
        // Lanes above the current one are always zero, so OR-in is enough.
        word_next = pack_q | ({24'd0, rx_data_i} << {cnt_q[1:0], 3'b000});

        unique case (state_q)
            RECV: begin
                if (rx_valid_i) begin
                    if (!full) begin
                        cnt_d = cnt_q + 12'd1;
                        if ((cnt_q[1:0] == 2'd3) || rx_last_i) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = cnt_q[10:2];
                            wr_data_d = word_next;
                            pack_d    = '0;
                        end else begin
                            pack_d = word_next;
                        end
                    end else if (!rx_last_i) begin
                        ovf_d = 1'b1;
                    end
                    if (rx_last_i) begin
                        len_d      = full ? CNT_W'(MAX_BYTES) : (cnt_q + 12'd1);
                        err_d      = rx_err_i | ovf_q;
                        done_d     = 1'b1;
                        cnt_d      = '0;
                        ovf_d      = 1'b0;
                        pack_d     = '0;
                        in_frame_d = 1'b0;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (rx_valid_i) begin
                    if (rx_last_i) begin
                        in_frame_d = 1'b0;
                        if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                    end else begin
                        in_frame_d = 1'b1;
                    end
                end
                // Ack only counts once the frame is visible to the bus.
                if (frame_ack_i && frame_valid_q) begin
                    frame_valid_d = 1'b0;
                    len_d         = '0;
                    err_d         = 1'b0;
                    state_d       = in_frame_d ? DROP : RECV;
                    in_frame_d    = 1'b0;
                end
            end
            DROP: begin
                if (rx_valid_i && rx_last_i) begin
                    if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                    state_d = RECV;
                end
            end
            default: state_d = RECV;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RECV;
            cnt_q         <= '0;
            pack_q        <= '0;
            ovf_q         <= 1'b0;
            in_frame_q    <= 1'b0;
            done_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            len_q         <= '0;
            err_q         <= 1'b0;
            drop_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pack_q        <= pack_d;
            ovf_q         <= ovf_d;
            in_frame_q    <= in_frame_d;
            done_q        <= done_d;
            frame_valid_q <= frame_valid_d;
            len_q         <= len_d;
            err_q         <= err_d;
            drop_q        <= drop_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    rx_buf_ram_512x32 u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en_q),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data_q),
        .re_i    (rd_en_i),
        .raddr_i (rd_addr_i),
        .rdata_o (rd_data_o)
    );

    // Length and error are loaded with the last byte but only shown with valid.
    assign frame_valid_o = frame_valid_q;
    assign frame_len_o   = frame_valid_q ? len_q : '0;
    assign frame_err_o   = frame_valid_q & err_q;
    assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_rx_buf_packer.sv
// Directed bench for rx_buf_packer with a read-data scoreboard.
module tb_rx_buf_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_last_i;
    logic        rx_err_i;
    logic        rd_en_i;
    logic [8:0]  rd_addr_i;
    logic [31:0] rd_data_o;
    logic        frame_valid_o;
    logic [11:0] frame_len_o;
    logic        frame_err_o;
    logic        frame_ack_i;
    logic [15:0] drop_cnt_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    rx_buf_packer dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid_i    (rx_valid_i),
        .rx_data_i     (rx_data_i),
        .rx_last_i     (rx_last_i),
        .rx_err_i      (rx_err_i),
        .rd_en_i       (rd_en_i),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .frame_valid_o (frame_valid_o),
        .frame_len_o   (frame_len_o),
        .frame_err_o   (frame_err_o),
        .frame_ack_i   (frame_ack_i),
        .drop_cnt_o    (drop_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic err);
        rx_valid_i = 1'b1;
        rx_data_i  = d;
        rx_last_i  = last;
        rx_err_i   = err;
        tick();
        rx_valid_i = 1'b0;
        rx_last_i  = 1'b0;
        rx_err_i   = 1'b0;
    endtask

    // Expected word goes into the scoreboard as the read is issued.
    task automatic read_word(input string tag, input logic [8:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        rd_en_i   = 1'b1;
        rd_addr_i = addr;
        tick();
        rd_en_i = 1'b0;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, rd_data_o, e);
        end
    endtask

    task automatic ack();
        frame_ack_i = 1'b1;
        tick();
        frame_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic v, input logic [11:0] len, input logic err);
        check({tag, "_valid"}, 32'(frame_valid_o), 32'(v));
        check({tag, "_len"},   32'(frame_len_o),   32'(len));
        check({tag, "_err"},   32'(frame_err_o),   32'(err));
    endtask

    initial begin
        logic [31:0] w;
        int b;
        rst = 1'b1; rx_valid_i = 1'b0; rx_data_i = '0; rx_last_i = 1'b0; rx_err_i = 1'b0;
        rd_en_i = 1'b0; rd_addr_i = '0; frame_ack_i = 1'b0;
        do_reset();

        check_frame("reset", 1'b0, 12'd0, 1'b0);
        check("reset_drop", 32'(drop_cnt_o), 32'd0);
        check("reset_rdata", rd_data_o, 32'd0);

        // Five-byte frame.
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        check("f1_valid_early", 32'(frame_valid_o), 32'd0);
        tick();
        check_frame("f1", 1'b1, 12'd5, 1'b0);
        read_word("f1_w0", 9'd0, 32'h4433_2211);
        read_word("f1_w1", 9'd1, 32'h0000_0055);
        check("f1_drop", 32'(drop_cnt_o), 32'd0);
        ack();
        check_frame("f1_ack", 1'b0, 12'd0, 1'b0);

        // One-byte frame with MAC error.
        send_byte(8'hAB, 1'b1, 1'b1);
        tick();
        check_frame("f2", 1'b1, 12'd1, 1'b1);
        read_word("f2_w0", 9'd0, 32'h0000_00AB);
        ack();

        // Overflowing frame: 2050 bytes, byte i = i[7:0].
        for (int i = 0; i < 2050; i++) begin
            b = i;
            send_byte(b[7:0], (i == 2049), 1'b0);
        end
        tick();
        check_frame("ovf", 1'b1, 12'd2048, 1'b1);
        read_word("ovf_w511", 9'd511, 32'hFFFE_FDFC);
        read_word("ovf_w0", 9'd0, 32'h0302_0100);
        for (int k = 100; k < 103; k++) begin
            b = 4 * k;
            w = {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
            read_word("ovf_wk", 9'(k), w);
        end
        ack();

        // Frame arriving during HOLD is dropped through DROP.
        send_byte(8'h5A, 1'b0, 1'b0);
        send_byte(8'h6B, 1'b1, 1'b0);
        tick();
        check_frame("f4a", 1'b1, 12'd2, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        read_word("hold_w0", 9'd0, 32'h0000_6B5A);
        ack();
        check("drop_ack_valid", 32'(frame_valid_o), 32'd0);
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h06, 1'b1, 1'b0);
        check("drop_cnt1", 32'(drop_cnt_o), 32'd1);
        check("drop_valid", 32'(frame_valid_o), 32'd0);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b1, 1'b0);
        tick();
        check_frame("f4b", 1'b1, 12'd2, 1'b0);
        read_word("f4b_w0", 9'd0, 32'h0000_BBAA);
        ack();

        // Ack coincident with the dropped frame's last byte.
        do_reset();
        send_byte(8'h77, 1'b1, 1'b0);
        tick();
        check_frame("f5a", 1'b1, 12'd1, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        frame_ack_i = 1'b1;
        send_byte(8'h03, 1'b1, 1'b0);
        frame_ack_i = 1'b0;
        check("coinc_drop", 32'(drop_cnt_o), 32'd1);
        check("coinc_valid", 32'(frame_valid_o), 32'd0);
        send_byte(8'h10, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0);
        send_byte(8'h30, 1'b1, 1'b0);
        tick();
        check_frame("f5b", 1'b1, 12'd3, 1'b0);
        read_word("f5b_w0", 9'd0, 32'h0030_2010);
        ack();

        // Reset in the middle of a frame.
        send_byte(8'hE1, 1'b0, 1'b0);
        send_byte(8'hE2, 1'b0, 1'b0);
        send_byte(8'hE3, 1'b0, 1'b0);
        do_reset();
        check_frame("rst_mid", 1'b0, 12'd0, 1'b0);
        check("rst_mid_drop", 32'(drop_cnt_o), 32'd0);
        check("rst_mid_rdata", rd_data_o, 32'd0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h04, 1'b1, 1'b0);
        tick();
        check_frame("f6", 1'b1, 12'd4, 1'b0);
        read_word("f6_w0", 9'd0, 32'h0403_0201);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
